// File: rtl/sat_narrow_pkg.sv
// Shared definitions for the saturating narrowing unit: mode encodings,
// default widths and the beat record carried through the skid buffer.
package sat_narrow_pkg;

    // Narrowing modes; the reserved code behaves as wrap.
    typedef enum logic [1:0] {
        MODE_WRAP  = 2'b00,
        MODE_SAT_S = 2'b01,
        MODE_SAT_U = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    localparam int unsigned DEF_INPUT_DWIDTH  = 16;
    localparam int unsigned DEF_OUTPUT_DWIDTH = 8;
    localparam int unsigned DEF_CNT_WIDTH     = 8;

    // Beat record at the default narrow width. The top re-declares the
    // same shape at its own parameterised width.
    typedef struct packed {
        logic [DEF_OUTPUT_DWIDTH-1:0] data;
        logic                         ovf;
    } beat_t;

    // Skid/stall occupancy states.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } skid_state_e;

endpackage

// File: rtl/sat_narrow_core.sv
// Combinational range check and wrap/clamp of a wide signed value into a
// narrow field. No state; the top registers the result with the beat.
module narrow_core
    import sat_narrow_pkg::*;
#(
    parameter int unsigned INPUT_DWIDTH  = 16,
    parameter int unsigned OUTPUT_DWIDTH = 8
) (
    input  logic [INPUT_DWIDTH-1:0]  in_data,
    input  logic [1:0]               mode,
    output logic [OUTPUT_DWIDTH-1:0] out_data,
    output logic                     out_ovf
);

    localparam int unsigned HI_S_W = INPUT_DWIDTH - OUTPUT_DWIDTH + 1;
    localparam int unsigned HI_U_W = INPUT_DWIDTH - OUTPUT_DWIDTH;

    localparam logic [OUTPUT_DWIDTH-1:0] SMAX = {1'b0, {(OUTPUT_DWIDTH-1){1'b1}}};
    localparam logic [OUTPUT_DWIDTH-1:0] SMIN = {1'b1, {(OUTPUT_DWIDTH-1){1'b0}}};
    localparam logic [OUTPUT_DWIDTH-1:0] UMAX = {OUTPUT_DWIDTH{1'b1}};
    localparam logic [OUTPUT_DWIDTH-1:0] UMIN = {OUTPUT_DWIDTH{1'b0}};

    logic [HI_S_W-1:0]        hi_s_bits_s;
    logic [HI_U_W-1:0]        hi_u_bits_s;
    logic                     fit_s_s;
    logic                     fit_u_s;
    logic                     neg_s;
    logic [OUTPUT_DWIDTH-1:0] low_s;

    // Signed fit: every bit from the narrow sign bit upward equals the
    // wide sign bit. Unsigned fit: every bit above the narrow field is 0.
    assign hi_s_bits_s = in_data[INPUT_DWIDTH-1:OUTPUT_DWIDTH-1];
    assign hi_u_bits_s = in_data[INPUT_DWIDTH-1:OUTPUT_DWIDTH];
    assign fit_s_s     = (&hi_s_bits_s) | (~|hi_s_bits_s);
    assign fit_u_s     = ~|hi_u_bits_s;
    assign neg_s       = in_data[INPUT_DWIDTH-1];
    assign low_s       = in_data[OUTPUT_DWIDTH-1:0];

    // Select wrap or clamp result and the matching out-of-range flag.
    always_comb begin
        out_data = low_s;
        out_ovf  = ~fit_s_s;
        case (mode)
            MODE_SAT_S: begin
                out_ovf = ~fit_s_s;
                if (fit_s_s) begin
                    out_data = low_s;
                end else if (neg_s) begin
                    out_data = SMIN;
                end else begin
                    out_data = SMAX;
                end
            end
            MODE_SAT_U: begin
                out_ovf = ~fit_u_s;
                if (fit_u_s) begin
                    out_data = low_s;
                end else if (neg_s) begin
                    out_data = UMIN;
                end else begin
                    out_data = UMAX;
                end
            end
            MODE_WRAP: begin
                out_data = low_s;
                out_ovf  = ~fit_s_s;
            end
            default: begin
                // Reserved code: identical to wrap.
                out_data = low_s;
                out_ovf  = ~fit_s_s;
            end
        endcase
    end

endmodule

// File: rtl/sat_narrow.sv
// Pipelined narrowing unit with saturation. The beat is narrowed at
// acceptance, then held in a main output register backed by one skid entry
// so that in_ready comes straight from a flop. Overflow statistics count
// every accepted out-of-range beat.
module sat_narrow
    import sat_narrow_pkg::*;
#(
    parameter int unsigned INPUT_DWIDTH  = 16,
    parameter int unsigned OUTPUT_DWIDTH = 8,
    parameter int unsigned CNT_WIDTH     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [INPUT_DWIDTH-1:0]  in_data,
    input  logic [1:0]               in_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUTPUT_DWIDTH-1:0] out_data,
    output logic                     out_ovf,
    input  logic                     ovf_clr,
    output logic                     ovf_sticky,
    output logic [CNT_WIDTH-1:0]     ovf_cnt
);

    // Beat record at this instance's narrow width.
    typedef struct packed {
        logic [OUTPUT_DWIDTH-1:0] data;
        logic                     ovf;
    } wbeat_t;

    localparam wbeat_t        BEAT_ZERO = '{data: {OUTPUT_DWIDTH{1'b0}}, ovf: 1'b0};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    skid_state_e              state_r;
    wbeat_t                   main_r;
    wbeat_t                   skid_r;
    logic                     in_ready_r;
    logic                     out_valid_r;
    logic                     sticky_r;
    logic [CNT_WIDTH-1:0]     cnt_r;

    logic [OUTPUT_DWIDTH-1:0] core_data_s;
    logic                     core_ovf_s;
    wbeat_t                   new_beat_s;
    logic                     accept_s;
    logic                     drain_s;

    narrow_core #(
        .INPUT_DWIDTH  (INPUT_DWIDTH),
        .OUTPUT_DWIDTH (OUTPUT_DWIDTH)
    ) u_core (
        .in_data  (in_data),
        .mode     (in_mode),
        .out_data (core_data_s),
        .out_ovf  (core_ovf_s)
    );

    // Mode is resolved here, so a later mode change never touches a
    // stored beat.
    assign new_beat_s = '{data: core_data_s, ovf: core_ovf_s};
    assign accept_s   = in_valid & in_ready_r;
    assign drain_s    = out_valid_r & out_ready;

    // Skid/stall FSM: moves beats between input, skid and main register and
    // keeps in_ready/out_valid as registered copies of the next occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            main_r      <= BEAT_ZERO;
            skid_r      <= BEAT_ZERO;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        main_r      <= new_beat_s;
                        state_r     <= ST_ONE;
                        out_valid_r <= 1'b1;
                        in_ready_r  <= 1'b1;
                    end else begin
                        state_r     <= ST_EMPTY;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept_s && drain_s) begin
                        // Pass-through: the new beat replaces the drained one.
                        main_r      <= new_beat_s;
                        state_r     <= ST_ONE;
                        out_valid_r <= 1'b1;
                        in_ready_r  <= 1'b1;
                    end else if (accept_s) begin
                        // Main is stalled; park the new beat in the skid entry.
                        skid_r      <= new_beat_s;
                        state_r     <= ST_FULL;
                        out_valid_r <= 1'b1;
                        in_ready_r  <= 1'b0;
                    end else if (drain_s) begin
                        state_r     <= ST_EMPTY;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end else begin
                        state_r     <= ST_ONE;
                        out_valid_r <= 1'b1;
                        in_ready_r  <= 1'b1;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a drain can happen.
                    if (drain_s) begin
                        main_r      <= skid_r;
                        state_r     <= ST_ONE;
                        out_valid_r <= 1'b1;
                        in_ready_r  <= 1'b1;
                    end else begin
                        state_r     <= ST_FULL;
                        out_valid_r <= 1'b1;
                        in_ready_r  <= 1'b0;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean empty state.
                    state_r     <= ST_EMPTY;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    // Overflow statistics: clear first, then count the accepted event, with
    // the counter pinned at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_r <= 1'b0;
            cnt_r    <= {CNT_WIDTH{1'b0}};
        end else if (ovf_clr) begin
            if (accept_s && new_beat_s.ovf) begin
                sticky_r <= 1'b1;
                cnt_r    <= CNT_ONE;
            end else begin
                sticky_r <= 1'b0;
                cnt_r    <= {CNT_WIDTH{1'b0}};
            end
        end else if (accept_s && new_beat_s.ovf) begin
            sticky_r <= 1'b1;
            if (cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            sticky_r <= sticky_r;
            cnt_r    <= cnt_r;
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_data   = main_r.data;
    assign out_ovf    = main_r.ovf;
    assign ovf_sticky = sticky_r;
    assign ovf_cnt    = cnt_r;

endmodule

// File: tb/tb_sat_narrow.sv
// Self-checking bench for sat_narrow: directed scenarios plus randomized
// traffic against an arithmetic reference model and a two-deep FIFO model.
module tb_sat_narrow;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_ovf;
    logic        ovf_clr;
    logic        ovf_sticky;
    logic [7:0]  ovf_cnt;

    typedef struct {
        logic [7:0] data;
        logic       ovf;
    } ent_t;

    ent_t exp_q[$];
    ent_t got_q[$];
    int   m_cnt;
    logic m_sticky;
    int   checks;
    int   errors;

    sat_narrow dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_mode    (in_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ovf    (out_ovf),
        .ovf_clr    (ovf_clr),
        .ovf_sticky (ovf_sticky),
        .ovf_cnt    (ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference narrowing computed from the integer value of the input.
    function automatic ent_t ref_narrow(input logic [15:0] d, input logic [1:0] m);
        ent_t e;
        int   x;
        x = int'($signed(d));
        if (m == 2'b01) begin
            e.ovf  = (x < -128) || (x > 127);
            if (x > 127)       e.data = 8'h7F;
            else if (x < -128) e.data = 8'h80;
            else               e.data = x[7:0];
        end else if (m == 2'b10) begin
            e.ovf  = (x < 0) || (x > 255);
            if (x < 0)         e.data = 8'h00;
            else if (x > 255)  e.data = 8'hFF;
            else               e.data = x[7:0];
        end else begin
            e.ovf  = (x < -128) || (x > 127);
            e.data = x[7:0];
        end
        return e;
    endfunction

    // One clock cycle: drive, check against the model mid-cycle, advance.
    task automatic cycle(input logic v, input logic [15:0] d, input logic [1:0] m,
                         input logic ordy, input logic clr);
        ent_t e;
        ent_t h;
        logic acc;
        logic drn;
        in_valid  = v;
        in_data   = d;
        in_mode   = m;
        out_ready = ordy;
        ovf_clr   = clr;
        @(negedge clk);
        check_eq("in_ready", in_ready, exp_q.size() < 2);
        check_eq("out_valid", out_valid, exp_q.size() != 0);
        check_eq("ovf_cnt", ovf_cnt, m_cnt);
        check_eq("ovf_sticky", ovf_sticky, m_sticky);
        acc = v && (exp_q.size() < 2);
        drn = ordy && (exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            h = exp_q[0];
            check_eq("out_data", out_data, h.data);
            check_eq("out_ovf", out_ovf, h.ovf);
        end
        if (drn) begin
            h = exp_q.pop_front();
            got_q.push_back('{data: out_data, ovf: out_ovf});
        end
        e = ref_narrow(d, m);
        if (acc) exp_q.push_back(e);
        if (clr) begin
            m_cnt    = 0;
            m_sticky = 1'b0;
        end
        if (acc && e.ovf) begin
            m_sticky = 1'b1;
            if (m_cnt < 255) m_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_cnt    = 0;
        m_sticky = 1'b0;
    endtask

    initial begin
        logic [15:0] ss_in  [5];
        logic [7:0]  ss_out [5];
        logic        ss_ovf [5];
        logic [15:0] su_in  [5];
        logic [1:0]  su_md  [5];
        logic [7:0]  su_out [5];
        logic        su_ovf [5];
        logic [15:0] rd;
        checks = 0;
        errors = 0;
        ss_in  = '{16'h007F, 16'h0080, 16'hFF80, 16'hFF7F, 16'h8000};
        ss_out = '{8'h7F, 8'h7F, 8'h80, 8'h80, 8'h80};
        ss_ovf = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        su_in  = '{16'hFFFF, 16'h00FF, 16'h0100, 16'h0123, 16'h0123};
        su_md  = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b11};
        su_out = '{8'h00, 8'hFF, 8'hFF, 8'h23, 8'h23};
        su_ovf = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

        // Reset held for three cycles.
        in_valid = 1'b0; in_data = 16'h0000; in_mode = 2'b00;
        out_ready = 1'b0; ovf_clr = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_ovf_cnt", ovf_cnt, 8'h00);
        check_eq("rst_sticky", ovf_sticky, 1'b0);
        check_eq("rst_out_data", out_data, 8'h00);
        rst_n = 1'b1;

        // First beat after reset.
        got_q.delete();
        cycle(1'b1, 16'h0042, 2'b01, 1'b1, 1'b0);
        check_eq("first_valid", out_valid, 1'b1);
        check_eq("first_data", out_data, 8'h42);
        check_eq("first_ovf", out_ovf, 1'b0);
        cycle(1'b0, 16'h0000, 2'b00, 1'b1, 1'b0);

        // SAT_S boundaries back-to-back.
        got_q.delete();
        for (int i = 0; i < 5; i++) cycle(1'b1, ss_in[i], 2'b01, 1'b1, 1'b0);
        cycle(1'b0, 16'h0000, 2'b00, 1'b1, 1'b0);
        check_eq("ss_count", got_q.size(), 5);
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            check_eq($sformatf("ss_data%0d", i), got_q[i].data, ss_out[i]);
            check_eq($sformatf("ss_ovf%0d", i), got_q[i].ovf, ss_ovf[i]);
        end
        check_eq("ss_ovf_cnt", ovf_cnt, 8'd3);

        // SAT_U, WRAP and reserved mode.
        got_q.delete();
        for (int i = 0; i < 5; i++) cycle(1'b1, su_in[i], su_md[i], 1'b1, 1'b0);
        cycle(1'b0, 16'h0000, 2'b00, 1'b1, 1'b0);
        check_eq("su_count", got_q.size(), 5);
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            check_eq($sformatf("su_data%0d", i), got_q[i].data, su_out[i]);
            check_eq($sformatf("su_ovf%0d", i), got_q[i].ovf, su_ovf[i]);
        end

        // Backpressure with three beats.
        got_q.delete();
        cycle(1'b1, 16'h0011, 2'b00, 1'b0, 1'b0);
        cycle(1'b1, 16'h0022, 2'b00, 1'b0, 1'b0);
        check_eq("bp_in_ready", in_ready, 1'b0);
        check_eq("bp_hold_a", out_data, 8'h11);
        cycle(1'b1, 16'h0033, 2'b00, 1'b0, 1'b0);
        check_eq("bp_hold_a2", out_data, 8'h11);
        cycle(1'b1, 16'h0033, 2'b00, 1'b1, 1'b0);
        cycle(1'b1, 16'h0033, 2'b00, 1'b1, 1'b0);
        cycle(1'b0, 16'h0000, 2'b00, 1'b1, 1'b0);
        cycle(1'b0, 16'h0000, 2'b00, 1'b1, 1'b0);
        check_eq("bp_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check_eq("bp_a", got_q[0].data, 8'h11);
            check_eq("bp_b", got_q[1].data, 8'h22);
            check_eq("bp_c", got_q[2].data, 8'h33);
        end

        // Counter saturation, clear with event, clear alone.
        for (int i = 0; i < 300; i++) cycle(1'b1, 16'h8000, 2'b01, 1'b1, 1'b0);
        check_eq("sat_cnt", ovf_cnt, 8'hFF);
        check_eq("sat_sticky", ovf_sticky, 1'b1);
        cycle(1'b1, 16'h8000, 2'b01, 1'b1, 1'b1);
        check_eq("clr_evt_cnt", ovf_cnt, 8'h01);
        check_eq("clr_evt_sticky", ovf_sticky, 1'b1);
        cycle(1'b0, 16'h0000, 2'b00, 1'b1, 1'b1);
        check_eq("clr_cnt", ovf_cnt, 8'h00);
        check_eq("clr_sticky", ovf_sticky, 1'b0);

        // Asynchronous reset while FULL.
        cycle(1'b1, 16'h0055, 2'b00, 1'b0, 1'b0);
        cycle(1'b1, 16'h0066, 2'b00, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", out_valid, 1'b0);
        check_eq("arst_in_ready", in_ready, 1'b1);
        check_eq("arst_out_data", out_data, 8'h00);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0000, 2'b00, 1'b1, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 2))
                0:       rd = 16'($urandom);
                1:       rd = 16'($urandom_range(0, 1023)) - 16'd512;
                default: rd = 16'($urandom_range(0, 767)) - 16'd256;
            endcase
            cycle(1'($urandom_range(0, 3) != 0), rd, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 63) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sat_narrow.md
Name: sat_narrow

Overview:
- Pipelined narrowing unit with saturation, the inverse of the pipeline's sign-extension path.
- Converts a wide signed datapath value (default 16-bit) into a narrow field (default 8-bit) for byte stores and immediate re-packing.
- Supports wrap, signed-saturate and unsigned-saturate modes, and flags every out-of-range value.
- Decoupled valid/ready on both sides, with a skid buffer so in_ready is driven from a register; sits between the EX result bus and the MEM store-data path.

Parameters:
- INPUT_DWIDTH, 16, width of the wide signed input value.
- OUTPUT_DWIDTH, 8, width of the narrowed result; must be >= 2 and < INPUT_DWIDTH.
- CNT_WIDTH, 8, width of the saturating overflow event counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  unit can accept a beat; driven from a register.
- in_data  input  INPUT_DWIDTH  signed wide value.
- in_mode  input  2  00 WRAP, 01 SAT_S, 10 SAT_U, 11 reserved (treated as WRAP).
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  OUTPUT_DWIDTH  narrowed result.
- out_ovf  output  1  input was out of range for the selected mode; qualified by out_valid.
- ovf_clr  input  1  synchronous clear of ovf_sticky and ovf_cnt.
- ovf_sticky  output  1  set by any accepted out-of-range beat.
- ovf_cnt  output  CNT_WIDTH  number of accepted out-of-range beats; saturates at all-ones.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_data=0, out_ovf=0, in_ready=1, ovf_sticky=0, ovf_cnt=0.
  - Skid buffer is emptied.
  - Beats in flight when reset is asserted are dropped.
  - First acceptance is possible on the first rising edge after rst_n deasserts.
- Transfers:
  - An input transfer occurs when in_valid and in_ready are both 1 at a rising edge.
  - An output transfer occurs when out_valid and out_ready are both 1 at a rising edge.
- Storage and latency:
  - Two entries: a main output register and one skid entry.
  - Latency is 1 cycle: a beat accepted at edge N is visible on out_data at edge N+1.
  - Throughput is 1 beat/cycle while out_ready stays 1.
- Skid and stall control:
  - States: EMPTY (main invalid), ONE (main valid, skid empty), FULL (both valid).
  - EMPTY, accept: go to ONE.
  - ONE, accept with no drain: go to FULL.
  - ONE, drain with no accept: go to EMPTY.
  - ONE, accept and drain in the same cycle: stay in ONE; main is replaced by the new beat.
  - FULL, drain: the skid entry moves to main; go to ONE.
  - in_ready = 0 exactly in FULL. No accept is possible in FULL, so no beat is lost.
- While out_valid=1 and out_ready=0, out_data and out_ovf must hold stable.
- Range checks, with x = in_data as a signed value and W = OUTPUT_DWIDTH:
  - Signed fit: x is in [-2^(W-1), 2^(W-1)-1], i.e. in_data[INPUT_DWIDTH-1:W-1] is all equal.
  - Unsigned fit: x is in [0, 2^W-1], i.e. in_data[INPUT_DWIDTH-1:W] is all zero.
- Mode results:
  - WRAP: out_data = in_data[W-1:0]; out_ovf = not signed fit.
  - SAT_S: out_data = x if it fits; 0x7F (2^(W-1)-1) if x > max; 0x80 (-2^(W-1)) if x < min. out_ovf = not signed fit.
  - SAT_U: out_data = x if it fits; 0 if x < 0; 0xFF if x > 2^W-1. out_ovf = not unsigned fit.
  - Mode 11 behaves exactly as WRAP.
- Mode and result are computed at input acceptance and stored with the beat. A mode change later does not affect stored beats.
- Overflow statistics:
  - Updated on input transfer of a beat with ovf=1.
  - ovf_sticky goes to 1; ovf_cnt increments unless already all-ones, where it holds.
  - ovf_clr alone: ovf_sticky=0, ovf_cnt=0 at the next edge.
  - ovf_clr in the same cycle as an overflowing accept: ovf_sticky=1, ovf_cnt=1 (the clear applies first, then the event counts).

Decomposition:
- Shared package sat_narrow_pkg:
  - Mode encodings MODE_WRAP=2'b00, MODE_SAT_S=2'b01, MODE_SAT_U=2'b10.
  - Beat record type {data, ovf}.
- Sub-module narrow_core: purely combinational fit check and clamp/wrap. It is parameterized by both widths and instantiated once on the input side.
- sat_narrow owns the skid buffer, the handshake control and the statistics.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release -> out_valid=0, in_ready=1, ovf_cnt=0. Then SAT_S, in_data=0x0042 -> next cycle out_data=0x42, out_ovf=0.
- SAT_S boundaries: stream 0x007F, 0x0080, 0xFF80, 0xFF7F, 0x8000 back-to-back with out_ready=1:
  - out_data = 0x7F, 0x7F, 0x80, 0x80, 0x80.
  - out_ovf = 0, 1, 0, 1, 1.
  - ovf_cnt = 3; one beat per cycle.
- SAT_U and WRAP: SAT_U 0xFFFF -> 0x00 ovf=1; SAT_U 0x00FF -> 0xFF ovf=0; SAT_U 0x0100 -> 0xFF ovf=1; WRAP 0x0123 -> 0x23 ovf=1; mode 11 with 0x0123 -> 0x23 ovf=1.
- Backpressure: out_ready=0 while sending 3 beats A, B, C -> A and B accepted, in_ready drops to 0 after B, out_data holds A. Raise out_ready -> outputs A, B, C in order with no loss or duplication.
- Statistics: force 300 overflowing beats -> ovf_cnt saturates at 0xFF. Assert ovf_clr together with an overflowing accept -> ovf_cnt=1, ovf_sticky=1. ovf_clr alone -> 0, 0.
- Reset mid-stream: assert rst_n=0 asynchronously while in FULL -> out_valid falls immediately without waiting for clk, in_ready=1, and no stale beat appears after release.
